// File: rtl/alu_dec_seq.sv
// alu_dec_seq: runs 6502 ADC/SBC on the shared 8-bit ALU. Binary mode takes one pass. Decimal mode takes five passes.
// Latency: done pulses 2 cycles after accept (binary), 6 (decimal), or 7 (decimal with ALU_DEC_CMOS_FLAGS_EN).
// Backpressure: req_ready is high only in IDLE; requests made while busy are dropped, not queued.
module alu_dec_seq #(
    parameter int             OPW     = 3,
    parameter logic [OPW-1:0] ALU_ADD = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_sub,
    input  logic           req_dec,
    input  logic [7:0]     req_a,
    input  logic [7:0]     req_b,
    input  logic           req_c,
    output logic           alu_own,
    output logic [7:0]     alu_ai,
    output logic [7:0]     alu_bi,
    output logic           alu_ci,
    output logic [OPW-1:0] alu_op,
    input  logic [7:0]     alu_out,
    input  logic           alu_n,
    input  logic           alu_v,
    input  logic           alu_z,
    input  logic           alu_c,
    output logic           done,
    output logic [7:0]     res,
    output logic           res_n,
    output logic           res_v,
    output logic           res_z,
    output logic           res_c
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BIN,
        S_LO,
        S_LOADJ,
        S_HI,
        S_HIADJ,
        S_FIX,
        S_DONE
    } state_t;

    state_t     state_q, state_d;

    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;            // operand B, already inverted for SBC
    logic       b7_q, b7_d;          // original B sign, needed by decimal ADC overflow
    logic       c_q, c_d;
    logic       sub_q, sub_d;
    logic       dec_q, dec_d;

    logic       bin_n_q, bin_n_d;
    logic       bin_v_q, bin_v_d;
    logic       bin_z_q, bin_z_d;
    logic       bin_c_q, bin_c_d;

    logic       hc_q, hc_d;
    logic       adj_q, adj_d;        // shared by low and high adjust; low adjust is consumed before HI
    logic [3:0] ls_q, ls_d;
    logic [3:0] lo_q, lo_d;
    logic [3:0] hs_q, hs_d;

    logic [7:0] res_q, res_d;
    logic       res_n_q, res_n_d;
    logic       res_v_q, res_v_d;
    logic       res_z_q, res_z_d;
    logic       res_c_q, res_c_d;

    logic       nib_gt9;
    logic [7:0] adj_val;

    assign nib_gt9 = (alu_out[4:0] > 5'd9);
    assign adj_val = sub_q ? 8'h0A : 8'h06;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        b7_d      = b7_q;
        c_d       = c_q;
        sub_d     = sub_q;
        dec_d     = dec_q;
        bin_n_d   = bin_n_q;
        bin_v_d   = bin_v_q;
        bin_z_d   = bin_z_q;
        bin_c_d   = bin_c_q;
        hc_d      = hc_q;
        adj_d     = adj_q;
        ls_d      = ls_q;
        lo_d      = lo_q;
        hs_d      = hs_q;
        res_d     = res_q;
        res_n_d   = res_n_q;
        res_v_d   = res_v_q;
        res_z_d   = res_z_q;
        res_c_d   = res_c_q;
        req_ready = 1'b0;
        done      = 1'b0;
        alu_own   = 1'b0;
        alu_ai    = 8'h00;
        alu_bi    = 8'h00;
        alu_ci    = 1'b0;
        alu_op    = '0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    a_d     = req_a;
                    b_d     = req_sub ? ~req_b : req_b;
                    b7_d    = req_b[7];
                    c_d     = req_c;
                    sub_d   = req_sub;
                    dec_d   = req_dec;
                    state_d = S_BIN;
                end
            end

            S_BIN: begin
                alu_own = 1'b1;
                alu_op  = ALU_ADD;
                alu_ai  = a_q;
                alu_bi  = b_q;
                alu_ci  = c_q;
                bin_n_d = alu_n;
                bin_v_d = alu_v;
                bin_z_d = alu_z;
                bin_c_d = alu_c;
                if (dec_q) begin
                    state_d = S_LO;
                end else begin
                    res_d   = alu_out;
                    res_n_d = alu_n;
                    res_v_d = alu_v;
                    res_z_d = alu_z;
                    res_c_d = alu_c;
                    state_d = S_DONE;
                end
            end

            S_LO: begin
                alu_own = 1'b1;
                alu_op  = ALU_ADD;
                alu_ai  = {4'h0, a_q[3:0]};
                alu_bi  = {4'h0, b_q[3:0]};
                alu_ci  = c_q;
                ls_d    = alu_out[3:0];
                if (sub_q) begin
                    hc_d  = alu_out[4];
                    adj_d = ~alu_out[4];
                end else begin
                    hc_d  = nib_gt9;
                    adj_d = nib_gt9;
                end
                state_d = S_LOADJ;
            end

            S_LOADJ: begin
                alu_own = 1'b1;
                alu_op  = ALU_ADD;
                alu_ai  = {4'h0, ls_q};
                alu_bi  = adj_q ? adj_val : 8'h00;
                lo_d    = alu_out[3:0];
                state_d = S_HI;
            end

            S_HI: begin
                alu_own = 1'b1;
                alu_op  = ALU_ADD;
                alu_ai  = {4'h0, a_q[7:4]};
                alu_bi  = {4'h0, b_q[7:4]};
                alu_ci  = hc_q;
                hs_d    = alu_out[3:0];
                // NMOS decimal Z always comes from the binary sum.
                res_z_d = bin_z_q;
                if (sub_q) begin
                    res_c_d = alu_out[4];
                    adj_d   = ~alu_out[4];
                    res_n_d = bin_n_q;
                    res_v_d = bin_v_q;
                end else begin
                    res_c_d = nib_gt9;
                    adj_d   = nib_gt9;
                    res_n_d = alu_out[3];
                    res_v_d = (a_q[7] ^ alu_out[3]) & ~(a_q[7] ^ b7_q);
                end
                state_d = S_HIADJ;
            end

            S_HIADJ: begin
                alu_own = 1'b1;
                alu_op  = ALU_ADD;
                alu_ai  = {4'h0, hs_q};
                alu_bi  = adj_q ? adj_val : 8'h00;
                res_d   = {alu_out[3:0], lo_q};
`ifdef ALU_DEC_CMOS_FLAGS_EN
                state_d = S_FIX;
`else
                state_d = S_DONE;
`endif
            end

`ifdef ALU_DEC_CMOS_FLAGS_EN
            S_FIX: begin
                res_n_d = res_q[7];
                res_z_d = (res_q == 8'h00);
                state_d = S_DONE;
            end
`endif

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            b7_q    <= 1'b0;
            c_q     <= 1'b0;
            sub_q   <= 1'b0;
            dec_q   <= 1'b0;
            bin_n_q <= 1'b0;
            bin_v_q <= 1'b0;
            bin_z_q <= 1'b0;
            bin_c_q <= 1'b0;
            hc_q    <= 1'b0;
            adj_q   <= 1'b0;
            ls_q    <= 4'h0;
            lo_q    <= 4'h0;
            hs_q    <= 4'h0;
            res_q   <= 8'h00;
            res_n_q <= 1'b0;
            res_v_q <= 1'b0;
            res_z_q <= 1'b0;
            res_c_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            b7_q    <= b7_d;
            c_q     <= c_d;
            sub_q   <= sub_d;
            dec_q   <= dec_d;
            bin_n_q <= bin_n_d;
            bin_v_q <= bin_v_d;
            bin_z_q <= bin_z_d;
            bin_c_q <= bin_c_d;
            hc_q    <= hc_d;
            adj_q   <= adj_d;
            ls_q    <= ls_d;
            lo_q    <= lo_d;
            hs_q    <= hs_d;
            res_q   <= res_d;
            res_n_q <= res_n_d;
            res_v_q <= res_v_d;
            res_z_q <= res_z_d;
            res_c_q <= res_c_d;
        end
    end

    assign res   = res_q;
    assign res_n = res_n_q;
    assign res_v = res_v_q;
    assign res_z = res_z_q;
    assign res_c = res_c_q;

endmodule

// File: doc/alu_dec_seq.md
Name: alu_dec_seq

Overview:
- Multi-cycle sequencer that performs 6502 ADC/SBC, in both binary and decimal (BCD) mode, on the shared 8-bit binary ALU.
- Decimal mode takes several ALU passes: binary flags, low nibble, low adjust, high nibble, high adjust.
- Sits beside the ALU in the core datapath. While it owns the ALU, the core muxes the ALU inputs from this block.

Parameters:
- OPW, 3, ALU op-code width; matches the op encodings in defs.vh.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  start request; accepted when req_ready=1
- req_ready  out  1  high only in IDLE
- req_sub  in  1  0=ADC, 1=SBC
- req_dec  in  1  D flag; 1=decimal mode
- req_a  in  8  accumulator operand
- req_b  in  8  memory operand
- req_c  in  1  carry in
- alu_own  out  1  sequencer is driving the ALU this cycle
- alu_ai  out  8  ALU port a
- alu_bi  out  8  ALU port b
- alu_ci  out  1  ALU carry in
- alu_op  out  OPW  ALU op; always ALU_ADD while owning
- alu_out  in  8  ALU result
- alu_n, alu_v, alu_z, alu_c  in  1 each  ALU flags
- done  out  1  one-cycle pulse; result and flags valid
- res  out  8  result
- res_n, res_v, res_z, res_c  out  1 each  final flags

Behaviour:
- Reset: all outputs 0 except req_ready=1; state=IDLE. Reset mid-operation aborts it; no done pulse.
- Request latch: on accept (cycle 0), latch A, B'=req_sub?~req_b:req_b, C, sub, dec.
- States: IDLE -> BIN -> (dec? LO -> LOADJ -> HI -> HIADJ : DONE) -> DONE -> IDLE.
- alu_own=1 in BIN, LO, LOADJ, HI, HIADJ. Otherwise alu_own=0 and alu_* are driven 0.
- BIN: ai=A, bi=B', ci=C.
  - Capture bin_out, bin_n, bin_v, bin_z, bin_c.
  - Binary mode: res=bin_out, flags=bin flags.
- LO: ai={0,A[3:0]}, bi={0,B'[3:0]}, ci=C; ls=alu_out[4:0].
  - ADC: hc=(ls>9), adjust if hc.
  - SBC: hc=ls[4], adjust if !hc.
- LOADJ: ai={0,ls[3:0]}, bi=adjust?(sub?8'h0A:8'h06):0, ci=0; lo=alu_out[3:0].
- HI: ai={0,A[7:4]}, bi={0,B'[7:4]}, ci=hc; hs=alu_out[4:0].
  - ADC: N=hs[3], V=(A[7]^hs[3])&~(A[7]^req_b[7]), C=(hs>9), adjust if C.
  - SBC: C=hs[4], adjust if !C; N, V come from BIN.
- HIADJ: same add as LOADJ on hs[3:0]; hi=alu_out[3:0]; res={hi,lo}.
- Decimal Z: always bin_z (NMOS behaviour).
- DONE: done=1 for 1 cycle. res/flags hold until the next accept.
- Latency from accept: binary done at cycle 2; decimal done at cycle 6.
- req_valid while busy: ignored, not queued. Back-to-back: a request on the cycle after DONE (IDLE) is accepted.
- Invalid BCD digits: processed by the same rules, no error indication.

Optional Feature:
- Macro: ALU_DEC_CMOS_FLAGS_EN (65C02 decimal flags).
- Defined:
  - Decimal mode inserts one extra FIX state (alu_own=0) between HIADJ and DONE; decimal done at cycle 7.
  - res_n=res[7] and res_z=(res==0) from the final BCD result.
  - V and C unchanged.
- Undefined: NMOS flags as above; decimal done at cycle 6. Binary mode is identical either way.

Test Plan:
- Decimal ADC A=58 B=46 C=1 -> res=05, C=1, N=1, V=1, Z=0; done at cycle 6, alu_own high cycles 1-5.
- Decimal SBC A=46 B=12 C=1 -> res=34, C=1, N=0, V=0, Z=0; decimal SBC A=40 B=13 C=1 -> res=27, C=1.
- Binary ADC A=7F B=01 C=0 -> res=80, N=1, V=1, Z=0, C=0; done at cycle 2; alu_own only in cycle 1.
- Decimal ADC A=99 B=01 C=0:
  - Macro undefined -> res=00, C=1, Z=0, N=1, done at cycle 6.
  - ALU_DEC_CMOS_FLAGS_EN defined -> res=00, C=1, Z=1, N=0, done at cycle 7.
- rst_n low in the HI state -> next cycle req_ready=1, done=0, res=00, all flags 0; no done pulse afterwards.
- req_valid held high through two ops, second operand changed while busy -> second op accepted the cycle after done and uses the operands present at acceptance.
